sky130_sram_1rw1r_sched: RTL

SKY130_SRAM_1RW1R_SCHED -- requirements
Module: sky130_sram_1rw1r_sched

---
 rtl/sky130_sram_1rw1r_sched_pkg.sv | 15 +
 rtl/sky130_sram_1rw1r_sched_rr_arb2.sv | 26 ++
 rtl/sky130_sram_1rw1r_sched.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/sky130_sram_1rw1r_sched_pkg.sv
// Shared widths and response-tag type for the 1RW/1R SRAM request scheduler.
package sky130_sram_1rw1r_sched_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 4;
    localparam int DEF_NUM_WMASKS = 4;

    // One tag per macro port: which requester gets that port's dout next cycle.
    typedef struct packed {
        logic valid;
        logic requester;
        logic port;
    } rsp_tag_t;

endpackage

// File: rtl/sky130_sram_1rw1r_sched_rr_arb2.sv
// Two-way round-robin grant; the pointer moves to the loser only when both request.
module sram_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    logic rr;

    always_comb begin
        grant = req;
        if (&req) begin
            grant = rr ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr <= 1'b0;
        end else if (&req) begin
            rr <= ~rr;
        end
    end

endmodule

// File: rtl/sky130_sram_1rw1r_sched.sv
// Schedules two requesters onto a 1RW+1R SRAM macro; reads respond two cycles after accept.
module sky130_sram_1rw1r_sched
    import sky130_sram_1rw1r_sched_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NUM_WMASKS = DEF_NUM_WMASKS
) (
    input  logic                  clk0,
    input  logic                  rst,
    input  logic                  m0_valid,
    output logic                  m0_ready,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [NUM_WMASKS-1:0] m0_wmask,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_rvalid,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    input  logic                  m1_valid,
    output logic                  m1_ready,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [NUM_WMASKS-1:0] m1_wmask,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0,
    output logic                  sram_csb1,
    output logic [ADDR_WIDTH-1:0] sram_addr1,
    input  logic [DATA_WIDTH-1:0] sram_dout1
);

    logic                  wr0, wr1, rd0, rd1;
    logic [1:0]            wgrant;
    logic [ADDR_WIDTH-1:0] waddr;
    rsp_tag_t [1:0]        tag_d, tag_q;
    logic [1:0]            rsp_vld;
    logic [DATA_WIDTH-1:0] rsp_dat [2];

    assign wr0 = m0_valid & m0_we & ~rst;
    assign wr1 = m1_valid & m1_we & ~rst;
    assign rd0 = m0_valid & ~m0_we & ~rst;
    assign rd1 = m1_valid & ~m1_we & ~rst;

    sram_rr_arb2 u_arb (
        .clk   (clk0),
        .rst   (rst),
        .req   ({wr1, wr0}),
        .grant (wgrant)
    );

    always_comb begin
        m0_ready    = 1'b0;
        m1_ready    = 1'b0;
        sram_csb0   = 1'b1;
        sram_web0   = 1'b1;
        sram_wmask0 = '0;
        sram_addr0  = '0;
        sram_din0   = '0;
        sram_csb1   = 1'b1;
        sram_addr1  = '0;
        tag_d       = '0;
        waddr       = wgrant[0] ? m0_addr : m1_addr;

        if (wgrant[0]) begin
            m0_ready    = 1'b1;
            sram_csb0   = 1'b0;
            sram_web0   = 1'b0;
            sram_wmask0 = m0_wmask;
            sram_addr0  = m0_addr;
            sram_din0   = m0_wdata;
        end else if (wgrant[1]) begin
            m1_ready    = 1'b1;
            sram_csb0   = 1'b0;
            sram_web0   = 1'b0;
            sram_wmask0 = m1_wmask;
            sram_addr0  = m1_addr;
            sram_din0   = m1_wdata;
        end

        if (wr0 | wr1) begin
            // A read of the word being written waits a cycle so it sees the new data.
            if (rd1 && m1_addr != waddr) begin
                m1_ready   = 1'b1;
                sram_csb1  = 1'b0;
                sram_addr1 = m1_addr;
                tag_d[1]   = '{valid: 1'b1, requester: 1'b1, port: 1'b1};
            end else if (rd0 && m0_addr != waddr) begin
                m0_ready   = 1'b1;
                sram_csb1  = 1'b0;
                sram_addr1 = m0_addr;
                tag_d[1]   = '{valid: 1'b1, requester: 1'b0, port: 1'b1};
            end
        end else if (rd0 && rd1) begin
            m0_ready   = 1'b1;
            m1_ready   = 1'b1;
            sram_csb0  = 1'b0;
            sram_addr0 = m0_addr;
            sram_csb1  = 1'b0;
            sram_addr1 = m1_addr;
            tag_d[0]   = '{valid: 1'b1, requester: 1'b0, port: 1'b0};
            tag_d[1]   = '{valid: 1'b1, requester: 1'b1, port: 1'b1};
        end else if (rd0 || rd1) begin
            m0_ready   = rd0;
            m1_ready   = rd1;
            sram_csb1  = 1'b0;
            sram_addr1 = rd0 ? m0_addr : m1_addr;
            tag_d[1]   = '{valid: 1'b1, requester: rd1, port: 1'b1};
        end
    end

    // Route each tagged port's dout to its requester.
    always_comb begin
        rsp_vld    = '0;
        rsp_dat[0] = '0;
        rsp_dat[1] = '0;
        for (int t = 0; t < 2; t++) begin
            if (tag_q[t].valid) begin
                rsp_vld[tag_q[t].requester] = 1'b1;
                rsp_dat[tag_q[t].requester] = tag_q[t].port ? sram_dout1 : sram_dout0;
            end
        end
    end

    always_ff @(posedge clk0 or posedge rst) begin
        if (rst) begin
            tag_q     <= '0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            tag_q     <= tag_d;
            m0_rvalid <= rsp_vld[0];
            m1_rvalid <= rsp_vld[1];
            if (rsp_vld[0]) m0_rdata <= rsp_dat[0];
            if (rsp_vld[1]) m1_rdata <= rsp_dat[1];
        end
    end

endmodule
